cpu_sequencer: RTL

Multi-cycle fetch/execute controller for the minicpu. It owns the program counter, the A/B registers, the carry flag and the output port. It drives the 4-bit program ROM address and decodes the returned 8-bit instruction (opcode[7:4], immediate[3:0]). It adds run/single-step control so the core can be halted and stepped from a debug source.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/inst_decoder.sv | 33 +++
 rtl/cpu_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Purpose: shared types and defaults for the minicpu fetch/execute sequencer.
// Latency: none (types, parameters and enums only).
// Backpressure: none.
package cpu_pkg;

    // Default datapath widths.
    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 4;
    // MSB index of an instruction word, which is PROG_WIDTH+1 = 8 bits wide.
    localparam int PROG_WIDTH = 7;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'h0,
        OP_MOV_AB = 4'h1,
        OP_IN_A   = 4'h2,
        OP_MOV_AI = 4'h3,
        OP_MOV_BA = 4'h4,
        OP_ADD_B  = 4'h5,
        OP_IN_B   = 4'h6,
        OP_MOV_BI = 4'h7,
        OP_OUT_B  = 4'h9,
        OP_OUT_I  = 4'hB,
        OP_JNC    = 4'hE,
        OP_JMP    = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_A    = 2'd1,
        DST_B    = 2'd2,
        DST_OUT  = 2'd3
    } dst_e;

    typedef enum logic [2:0] {
        SRC_IM  = 3'd0,
        SRC_A   = 3'd1,
        SRC_B   = 3'd2,
        SRC_IN  = 3'd3,
        SRC_ADD = 3'd4
    } src_e;

    // Decoded control fields for one instruction.
    typedef struct packed {
        dst_e dst;
        src_e src;
        logic is_add;  // instruction writes carry from the adder
        logic add_b;   // adder operand is B (else A)
        logic jmp;     // unconditional jump to im
        logic jnc;     // jump to im when carry is clear
    } ctrl_t;

endpackage

// File: rtl/inst_decoder.sv
// Purpose: combinational decode of a 4-bit opcode into datapath control fields.
// Latency: combinational, zero cycles.
// Backpressure: none; unknown opcodes decode as NOP.
module inst_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] op,
    output ctrl_t      ctrl
);

    // Opcode to control mapping; the default is a NOP that writes nothing.
    always_comb begin
        ctrl        = '0;
        ctrl.dst    = DST_NONE;
        ctrl.src    = SRC_IM;
        case (opcode_e'(op))
            OP_ADD_A:  begin ctrl.dst = DST_A;   ctrl.src = SRC_ADD; ctrl.is_add = 1'b1; end
            OP_MOV_AB: begin ctrl.dst = DST_A;   ctrl.src = SRC_B;  end
            OP_IN_A:   begin ctrl.dst = DST_A;   ctrl.src = SRC_IN; end
            OP_MOV_AI: begin ctrl.dst = DST_A;   ctrl.src = SRC_IM; end
            OP_MOV_BA: begin ctrl.dst = DST_B;   ctrl.src = SRC_A;  end
            OP_ADD_B:  begin ctrl.dst = DST_B;   ctrl.src = SRC_ADD; ctrl.is_add = 1'b1; ctrl.add_b = 1'b1; end
            OP_IN_B:   begin ctrl.dst = DST_B;   ctrl.src = SRC_IN; end
            OP_MOV_BI: begin ctrl.dst = DST_B;   ctrl.src = SRC_IM; end
            OP_OUT_B:  begin ctrl.dst = DST_OUT; ctrl.src = SRC_B;  end
            OP_OUT_I:  begin ctrl.dst = DST_OUT; ctrl.src = SRC_IM; end
            OP_JNC:    ctrl.jnc = 1'b1;
            OP_JMP:    ctrl.jmp = 1'b1;
            default:   ctrl.dst = DST_NONE;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Purpose: minicpu fetch/execute controller with run/halt and single-step control.
// Latency: 2 cycles per instruction (FETCH latches ir, EXECUTE retires it).
// Backpressure: run low halts after the current instruction; step is honoured only in HALT.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [PROG_WIDTH:0]   rom_data,
    input  logic [DATA_W-1:0]     in_port,
    output logic [DATA_W-1:0]     out_port,
    input  logic                  run,
    input  logic                  step,
    output logic                  halted,
    output logic                  instr_done,
    output logic [ADDR_W-1:0]     pc
);

    state_e              state;
    logic [PROG_WIDTH:0] ir;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   b_reg;
    logic                carry;
    logic                step_pend;

    ctrl_t               ctrl;
    logic [DATA_W-1:0]   im;
    logic [DATA_W-1:0]   add_op;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   wr_val;
    logic                jump_taken;
    logic [ADDR_W-1:0]   pc_next;

    assign rom_addr = pc;

    inst_decoder u_dec (
        .op   (ir[7:4]),
        .ctrl (ctrl)
    );

    // Execute-stage datapath: adder, writeback source mux and next-pc select.
    always_comb begin
        im         = DATA_W'(ir[3:0]);
        add_op     = ctrl.add_b ? b_reg : a_reg;
        sum        = {1'b0, add_op} + {1'b0, im};
        wr_val     = im;
        case (ctrl.src)
            SRC_IM:  wr_val = im;
            SRC_A:   wr_val = a_reg;
            SRC_B:   wr_val = b_reg;
            SRC_IN:  wr_val = in_port;
            SRC_ADD: wr_val = sum[DATA_W-1:0];
            default: wr_val = im;
        endcase
        // JNC tests the carry left by the previous instruction.
        jump_taken = ctrl.jmp | (ctrl.jnc & ~carry);
        pc_next    = jump_taken ? ADDR_W'(ir[3:0]) : pc + ADDR_W'(1);
    end

    // Sequencer FSM with architectural registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HALT;
            pc         <= '0;
            ir         <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            carry      <= 1'b0;
            out_port   <= '0;
            step_pend  <= 1'b0;
            halted     <= 1'b1;
            instr_done <= 1'b0;
        end else begin
            case (state)
                ST_HALT: begin
                    instr_done <= 1'b0;
                    if (run) begin
                        state     <= ST_FETCH;
                        step_pend <= 1'b0;
                        halted    <= 1'b0;
                    end else if (step) begin
                        state     <= ST_FETCH;
                        step_pend <= 1'b1;
                        halted    <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    ir         <= rom_data;
                    state      <= ST_EXEC;
                    // Pulse lines up with the EXECUTE cycle that retires the instruction.
                    instr_done <= 1'b1;
                end
                ST_EXEC: begin
                    instr_done <= 1'b0;
                    pc         <= pc_next;
                    carry      <= ctrl.is_add ? sum[DATA_W] : 1'b0;
                    case (ctrl.dst)
                        DST_A:   a_reg    <= wr_val;
                        DST_B:   b_reg    <= wr_val;
                        DST_OUT: out_port <= wr_val;
                        default: ;
                    endcase
                    if (step_pend) begin
                        state     <= ST_HALT;
                        step_pend <= 1'b0;
                        halted    <= 1'b1;
                    end else if (run) begin
                        state     <= ST_FETCH;
                    end else begin
                        state     <= ST_HALT;
                        halted    <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_HALT;
                    halted     <= 1'b1;
                    instr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
